// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Responds on the core IO bus; read data is combinational from address.
module io_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
    parameter int          FIFO_AW     = 3,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] IO_memAddr_i,
    input  logic [31:0] IO_memWData_i,
    input  logic        IO_memWr_i,
    output logic [31:0] IO_memRData_o,
    output logic        uart_tx_o,
    output logic        txEmpty_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        div_q, div_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               ovf_q, ovf_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [7:0]         mem_q [DEPTH];

    logic        sel;
    logic [1:0]  off;
    logic        wr_tx, wr_st, wr_div;
    logic        full, empty, pop, push_ok;
    logic [31:0] status;
    logic        unused_bits;

    assign unused_bits = ^{IO_memWData_i[31:16], IO_memAddr_i[1:0]};

    assign sel    = IO_memAddr_i[31:4] == BASE_ADDR[31:4];
    assign off    = IO_memAddr_i[3:2];
    assign wr_tx  = IO_memWr_i && sel && (off == 2'd0);
    assign wr_st  = IO_memWr_i && sel && (off == 2'd1);
    assign wr_div = IO_memWr_i && sel && (off == 2'd2);

    assign full    = count_q == FULL_CNT;
    assign empty   = count_q == '0;
    assign push_ok = wr_tx && (!full || pop);

    // Serializer; the line is driven one cycle behind the state register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    cnt_d   = div_q - 16'd1;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (cnt_q == 16'd0) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    cnt_d   = div_q - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (cnt_q == 16'd0) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = div_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (cnt_q == 16'd0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        cnt_d   = div_q - 16'd1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        div_d    = div_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + (FIFO_AW+1)'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - (FIFO_AW+1)'(1);
        end
        // A new overflow outranks a clear in the same cycle.
        if (wr_st && IO_memWData_i[3]) begin
            ovf_d = 1'b0;
        end
        if (wr_tx && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (wr_div) begin
            div_d = (IO_memWData_i[15:0] == 16'd0) ? 16'd1
                                                   : IO_memWData_i[15:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            div_q    <= DEFAULT_DIV;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
            div_q    <= div_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= IO_memWData_i[7:0];
        end
    end

    always_comb begin
        status              = '0;
        status[0]           = full;
        status[1]           = state_q != IDLE;
        status[2]           = empty;
        status[3]           = ovf_q;
        status[4+FIFO_AW:4] = count_q;
    end

    always_comb begin
        IO_memRData_o = '0;
        if (sel) begin
            unique case (off)
                2'd1:    IO_memRData_o = status;
                2'd2:    IO_memRData_o = {16'b0, div_q};
                default: IO_memRData_o = '0;
            endcase
        end
    end

    assign uart_tx_o = tx_q;
    assign txEmpty_o = empty && (state_q == IDLE);

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: directed bench for io_uart_tx.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_io_uart_tx;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rdata;
    logic        tx;
    logic        tx_empty;

    int n_cmp = 0;
    int n_err = 0;

    io_uart_tx dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .IO_memAddr_i  (addr),
        .IO_memWData_i (wdata),
        .IO_memWr_i    (wr),
        .IO_memRData_o (rdata),
        .uart_tx_o     (tx),
        .txEmpty_o     (tx_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
        wdata = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] r);
        addr = a;
        #1;
        r = rdata;
    endtask

    task automatic frame(input string tag, input logic [7:0] b,
                         input int div);
        logic exp;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) exp = 1'b0;
            else if (i == 9) exp = 1'b1;
            else exp = b[i-1];
            for (int k = 0; k < div; k++) begin
                @(negedge clk);
                chk($sformatf("%s_bit%0d_c%0d", tag, i, k), {31'b0, tx},
                    {31'b0, exp});
            end
        end
    endtask

    task automatic send(input string tag, input logic [7:0] b,
                        input int div);
        bus_wr(BASE, {24'b0, b});
        chk({tag, "_lat0"}, {31'b0, tx}, 32'd1);
        @(negedge clk);
        chk({tag, "_lat1"}, {31'b0, tx}, 32'd1);
        frame(tag, b, div);
        chk({tag, "_empty"}, {31'b0, tx_empty}, 32'd1);
    endtask

    logic [31:0] r;

    initial begin
        reset_i = 1'b0;
        addr    = '0;
        wdata   = '0;
        wr      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b1;

        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_empty", {31'b0, tx_empty}, 32'd1);
        bus_rd(BASE + 32'h4, r);
        chk("rst_status", r, 32'h0000_0004);
        bus_rd(BASE + 32'h8, r);
        chk("rst_div", r, 32'd434);

        // Single frame at 4 cycles per bit.
        bus_wr(BASE + 32'h8, 32'd4);
        bus_rd(BASE + 32'h8, r);
        chk("div4", r, 32'd4);
        send("f55", 8'h55, 4);

        // Back-to-back frames with no idle gap.
        bus_wr(BASE, 32'h0000_00A5);
        bus_wr(BASE, 32'h0000_003C);
        bus_rd(BASE + 32'h4, r);
        chk("b2b_status", r, 32'h0000_0012);
        frame("fA5", 8'hA5, 4);
        frame("f3C", 8'h3C, 4);
        chk("b2b_empty", {31'b0, tx_empty}, 32'd1);

        // Fill the FIFO and overflow it.
        bus_wr(BASE + 32'h8, 32'd100);
        for (int i = 0; i < 10; i++) begin
            bus_wr(BASE, 32'h0);
        end
        bus_rd(BASE + 32'h4, r);
        chk("ovf_status", r, 32'h0000_008B);
        bus_rd(BASE, r);
        chk("txdata_rd0", r, 32'h0);
        bus_wr(BASE + 32'h4, 32'h8);
        bus_rd(BASE + 32'h4, r);
        chk("ovf_clear", r, 32'h0000_0083);

        // First pop at edge N+1; the next STOP->START pop is at N+1001.
        repeat (990) @(negedge clk);
        chk("pre_pop_tx", {31'b0, tx}, 32'd1);
        bus_wr(BASE, 32'h0);
        bus_rd(BASE + 32'h4, r);
        chk("full_push_pop", r, 32'h0000_0083);

        // Reset in the middle of a zero data bit.
        repeat (150) @(negedge clk);
        chk("mid_data_tx", {31'b0, tx}, 32'd0);
        reset_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b1;
        chk("mid_rst_tx", {31'b0, tx}, 32'd1);
        chk("mid_rst_empty", {31'b0, tx_empty}, 32'd1);
        bus_rd(BASE + 32'h4, r);
        chk("mid_rst_status", r, 32'h0000_0004);
        bus_rd(BASE + 32'h8, r);
        chk("mid_rst_div", r, 32'd434);

        // Divisor zero becomes one: a 10-cycle frame.
        bus_wr(BASE + 32'h8, 32'h0);
        bus_rd(BASE + 32'h8, r);
        chk("div0", r, 32'd1);
        send("f0F", 8'h0F, 1);

        // Outside the register window.
        bus_wr(BASE + 32'h10, 32'h0000_0077);
        chk("oob_empty", {31'b0, tx_empty}, 32'd1);
        @(negedge clk);
        chk("oob_tx", {31'b0, tx}, 32'd1);
        bus_rd(BASE + 32'h4, r);
        chk("oob_status", r, 32'h0000_0004);
        bus_rd(BASE + 32'h14, r);
        chk("oob_rd", r, 32'h0);
        bus_rd(BASE + 32'h18, r);
        chk("oob_rd_div", r, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Memory-mapped UART transmitter.
- Acts as the responder on the processor's IO bus: it decodes IO address, write-data and write-strobe, and drives combinational read data back to the core.
- Bytes written by software are buffered in a TX FIFO and serialized 8N1, LSB first, on a single output line.
- Sits beside data memory at the SoC top level; the IO bus is driven by the memory stage.

Parameters:
- BASE_ADDR, 32'h0040_0000, base of the 16-byte register window; must be 16-byte aligned.
- FIFO_AW, 3, log2 of TX FIFO depth (depth = 8).
- DEFAULT_DIV, 16'd434, reset value of the baud divisor (clock cycles per bit).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-low reset.
- IO_memAddr_i  in  32  byte address from the core.
- IO_memWData_i  in  32  write data.
- IO_memWr_i  in  1  write strobe; one write per asserted cycle.
- IO_memRData_o  out  32  read data, combinational from address.
- uart_tx_o  out  1  serial line, idle high, registered.
- txEmpty_o  out  1  high when FIFO is empty and the serializer is idle.

Behaviour:
Reset:
- Reset is reset_i==0 sampled on the clock edge.
- State after reset: uart_tx_o=1, FIFO empty (count=0, pointers 0), divisor=DEFAULT_DIV, overflow=0, FSM=IDLE, bit counter=0, txEmpty_o=1.
- Reset asserted mid-frame abandons the frame; uart_tx_o is high after that edge.

Address decode:
- The block is selected when IO_memAddr_i[31:4]==BASE_ADDR[31:4].
- Register offset is IO_memAddr_i[3:2]; bits [1:0] are ignored.
- Unselected address: reads return 0, writes are ignored.

Registers:
- Offset 0, TXDATA.
  - Write pushes IO_memWData_i[7:0].
  - Reads return 0.
- Offset 1, STATUS, read layout:
  - bit0 full (count==depth)
  - bit1 busy (FSM!=IDLE)
  - bit2 empty (count==0)
  - bit3 overflow (sticky)
  - bits[4+FIFO_AW:4] count
  - all other bits 0
- Offset 1, STATUS, write: writing bit3=1 clears overflow; other bits are ignored.
- Offset 2, DIV.
  - Read returns {16'b0, div}.
  - Write loads IO_memWData_i[15:0]; a written value of 0 is stored as 1.
  - A new value takes effect at the next bit boundary; the current bit completes with the old count.
- Offset 3: reads 0, writes ignored.

FIFO:
- Push is accepted when count<depth, or when count==depth and a pop occurs the same cycle.
- A rejected push drops the byte and sets overflow in the same edge.
- Simultaneous push and pop leave count unchanged.
- Pointers wrap modulo depth.
- Overflow-clear and a new overflow in the same cycle: set wins.

Serializer FSM (IDLE, START, DATA, STOP):
- IDLE:
  - uart_tx_o=1.
  - If FIFO is non-empty: pop into shift register, load baud counter with div-1, go to START.
- START:
  - uart_tx_o=0 for div cycles, then go to DATA with bitIdx=0.
- DATA:
  - uart_tx_o=shift[0] for div cycles per bit, then shift right.
  - After bitIdx==7 completes, go to STOP.
- STOP:
  - uart_tx_o=1 for div cycles.
  - Then: if FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
- Frame length is exactly 10*div cycles.

Latency and outputs:
- A TXDATA write at edge N into an empty FIFO with the FSM in IDLE: pop at edge N+1, uart_tx_o low after edge N+2.
- txEmpty_o = (count==0) && FSM==IDLE; registered state, no combinational path from IO inputs.
- IO_memRData_o is purely combinational from IO_memAddr_i and internal state. It does not depend on IO_memWr_i; a read in the same cycle as a write returns pre-write state.

Test Plan:
- Reset with reset_i=0 for 2 cycles -> uart_tx_o=1, txEmpty_o=1, STATUS read = 32'h0000_0004, DIV read = 434.
- Write DIV=4, then TXDATA=0x55 -> line low 2 edges after the write, then 40-cycle frame 0,1,0,1,0,1,0,1,0,1 at 4 cycles per bit; txEmpty_o returns 1 after the stop bit.
- With DIV=4, write 0xA5 then 0x3C on consecutive cycles -> two 40-cycle frames with no idle gap (stop bit immediately followed by start bit); STATUS count reads 1 during the first frame.
- With DIV=100, write 10 bytes back-to-back -> first byte popped and FIFO fills to 8; the 10th write sets overflow; STATUS = full|busy|overflow with count=8 (32'h0000_008B); writing STATUS with 0x8 clears bit3 only.
- With the FIFO full, push on the same cycle the FSM pops (STOP -> START) -> push accepted, count stays 8, overflow stays 0.
- Write DIV=0 -> DIV reads 1; a frame lasts 10 cycles. Write to BASE_ADDR+0x10 -> ignored, and reads there return 0.
- Assert reset_i=0 mid-DATA -> uart_tx_o=1 after that edge, FIFO empty, DIV back to 434.
